// File: rtl/imm_gen_arbiter_pkg.sv
// imm_pkg: opcode and immediate-select encodings shared by the arbiter and extend unit
package imm_pkg;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;
  // Returns {has_imm, imm_src}
  function automatic logic [3:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm_src_of = {1'b1, IMM_I};
      OP_STORE:                            imm_src_of = {1'b1, IMM_S};
      OP_BRANCH:                           imm_src_of = {1'b1, IMM_B};
      OP_LUI, OP_AUIPC:                    imm_src_of = {1'b1, IMM_U};
      OP_JAL:                              imm_src_of = {1'b1, IMM_J};
      default:                             imm_src_of = {1'b0, IMM_NONE};
    endcase
  endfunction
endpackage

// File: rtl/imm_gen_arbiter_extend.sv
// imm_gen_arbiter_extend: RISC-V immediate extend unit fed with instruction bits [31:7]
module imm_gen_arbiter_extend
  import imm_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int C_WIDTH = 2,
  parameter int I_WIDTH = 31
) (
  input  logic [WIDTH:0]   instr,
  input  logic [C_WIDTH:0] imm_src,
  output logic [I_WIDTH:0] imm_ext
);
  logic [WIDTH+7:7] ir;
  assign ir = instr;
  always_comb
    imm_ext = imm_src == IMM_I ? {{20{ir[31]}}, ir[31:20]} :
              imm_src == IMM_S ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
              imm_src == IMM_B ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} :
              imm_src == IMM_U ? {ir[31:12], 12'b0} :
              imm_src == IMM_J ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0} :
              '0;
endmodule

// File: rtl/imm_gen_arbiter.sv
// imm_gen_arbiter: round-robin share of one immediate extend unit between two decode lanes,
// with a one-entry valid/ready output register toward rename.
module imm_gen_arbiter
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NLANE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [NLANE-1:0] req_valid,
  input  logic [XLEN-1:0]  req_instr0,
  input  logic [XLEN-1:0]  req_instr1,
  output logic [NLANE-1:0] req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_lane,
  output logic             out_has_imm
);
  logic            rr_ptr;
  logic            accept;
  logic            any;
  logic            g;
  logic            xfer;
  logic [XLEN-1:0] instr;
  logic [3:0]      dec;
  logic [XLEN-1:0] ext;
  assign accept    = !flush && (!out_valid || out_ready);
  assign any       = |req_valid;
  assign g         = &req_valid ? rr_ptr : req_valid[1];
  assign xfer      = any && accept;
  assign req_ready = xfer ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign instr     = g ? req_instr1 : req_instr0;
  assign dec       = imm_src_of(instr[6:0]);
  imm_gen_arbiter_extend #(.WIDTH(24), .C_WIDTH(2), .I_WIDTH(31)) u_extend (
    .instr   (instr[31:7]),
    .imm_src (dec[2:0]),
    .imm_ext (ext)
  );
  // A stalled lane keeps its turn: the pointer only moves on a real transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_lane    <= 1'b0;
      out_has_imm <= 1'b0;
      rr_ptr      <= 1'b0;
    end else if (xfer) begin
      out_valid   <= 1'b1;
      out_imm     <= ext;
      out_lane    <= g;
      out_has_imm <= dec[3];
      rr_ptr      <= ~g;
    end else if (flush || out_ready) begin
      out_valid   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_imm_gen_arbiter.sv
// tb_imm_gen_arbiter: scoreboard bench with a behavioural model of arbitration and immediate decode
module tb_imm_gen_arbiter;
  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic [1:0]  req_valid = 0;
  logic [31:0] req_instr0 = 0;
  logic [31:0] req_instr1 = 0;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_imm;
  logic        out_lane;
  logic        out_has_imm;

  imm_gen_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_instr0  (req_instr0),
    .req_instr1  (req_instr1),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_lane    (out_lane),
    .out_has_imm (out_has_imm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [33:0] q[$];
  logic mv = 0;
  int turn = 0;
  int acc_lane = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value written from the ISA field layout using arithmetic on the whole word
  function automatic logic [32:0] ref_imm(input logic [31:0] x);
    logic [31:0] sx;
    logic [31:0] r;
    sx = {32{x[31]}};
    case (x[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: r = $signed(x) >>> 20;
      7'h23: r = (sx << 12) | (32'(x[31:25]) << 5) | 32'(x[11:7]);
      7'h63: r = (sx << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      7'h37, 7'h17: r = x & 32'hFFFFF000;
      7'h6F: r = (sx << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      default: return {1'b0, 32'h0};
    endcase
    return {1'b1, r};
  endfunction

  task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic ordy, input logic fl);
    int g;
    logic acc;
    logic [32:0] e;
    @(posedge clk);
    #1;
    req_valid = v; req_instr0 = i0; req_instr1 = i1; out_ready = ordy; flush = fl;
    #2;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    g = (v == 2'b11) ? turn : (v[1] ? 1 : 0);
    acc = !fl && (!mv || ordy);
    chk("req_ready", {30'b0, req_ready}, (acc && v != 0) ? (g == 1 ? 32'd2 : 32'd1) : 32'd0);
    acc_lane = -1;
    if (fl && mv) void'(q.pop_front());
    if (acc && v != 0) begin
      e = ref_imm(g == 1 ? i1 : i0);
      q.push_back({g == 1, e});
      mv = 1;
      turn = 1 - g;
      acc_lane = g;
    end else if (fl || ordy) mv = 0;
  endtask

  task automatic do_reset_mid();
    @(posedge clk);
    #2;
    reset = 1; req_valid = 0; flush = 0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_lane", {31'b0, out_lane}, 0);
    chk("rst_out_has_imm", {31'b0, out_has_imm}, 0);
    q.delete(); mv = 0; turn = 0;
    @(posedge clk);
    #2;
    reset = 0;
  endtask

  // Monitor: compares the held result against the scoreboard front while valid, pops on handshake
  always @(negedge clk) begin
    if (!reset && out_valid && !flush) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: out_imm %h lane %0d with empty scoreboard", out_imm, out_lane);
      end else begin
        chk("out_imm", out_imm, q[0][31:0]);
        chk("out_has_imm", {31'b0, out_has_imm}, {31'b0, q[0][32]});
        chk("out_lane", {31'b0, out_lane}, {31'b0, q[0][33]});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    return {$urandom() & 32'hFFFFFF80} | (($urandom_range(0, 11) < 10) ?
           32'(ops[$urandom_range(0, 9)]) : 32'($urandom_range(0, 127)));
  endfunction

  initial begin
    logic [31:0] p0, p1;
    logic [1:0] pend;
    #2;
    chk("init_out_valid", {31'b0, out_valid}, 0);
    chk("init_out_imm", out_imm, 0);
    chk("init_out_lane", {31'b0, out_lane}, 0);
    chk("init_out_has_imm", {31'b0, out_has_imm}, 0);
    #10 reset = 0;
    step(2'b01, 32'hFFF00093, 0, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    step(2'b11, 32'h123450B7, 32'h0080006F, 1, 0);
    step(2'b10, 0, 32'h0080006F, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    step(2'b10, 0, 32'hFE000EE3, 1, 0);
    for (int i = 0; i < 3; i++) step(2'b11, 32'h00500113, 32'h00112023, 0, 0);
    step(2'b11, 32'h00500113, 32'h00112023, 1, 0);
    step(2'b10, 0, 32'h00112023, 1, 0);
    step(2'b01, 32'h002081B3, 0, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    step(2'b01, 32'h00C00093, 0, 1, 0);
    step(2'b11, 32'h00400193, 32'h008000EF, 1, 1);
    step(2'b11, 32'h00400193, 32'h008000EF, 1, 0);
    step(2'b01, 32'h00400193, 0, 1, 0);
    step(2'b11, 32'hABCDE037, 32'h7FF00013, 0, 0);
    do_reset_mid();
    step(2'b11, 32'h80000017, 32'hFFDFF06F, 1, 0);
    step(2'b10, 0, 32'hFFDFF06F, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    pend = 0; p0 = 0; p1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pend[0] && $urandom_range(0, 9) < 6) begin pend[0] = 1; p0 = rand_instr(); end
      if (!pend[1] && $urandom_range(0, 9) < 6) begin pend[1] = 1; p1 = rand_instr(); end
      step(pend, p0, p1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      if (acc_lane == 0) pend[0] = 0;
      if (acc_lane == 1) pend[1] = 0;
      if (c == 300) begin
        do_reset_mid();
        pend = 0;
      end
    end
    step(2'b00, 0, 0, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
